// File: rtl/avm_mem_tester.sv
// ---------------------------------------------------------------------------
// avm_mem_tester
//   Avalon-MM traffic generator / checker for memory bring-up. On start it
//   writes a 32-bit Galois LFSR sequence over NUM_WORDS consecutive words from
//   BASE_ADDR, then reads the range back with up to MAX_PEND reads in flight,
//   and compares each returned word against a second LFSR restarted at SEED.
//
// Ports
//   clk_clk, reset_reset_n        clock, asynchronous active-low reset
//   start                         1-cycle pulse, ignored while busy
//   busy / done / pass            run status; pass is meaningful when done
//   error_count                   mismatched words, saturating
//   first_err_addr                byte address of the first mismatch
//   avm_*                         Avalon-MM master (address, read, write,
//                                 writedata, byteenable, readdata,
//                                 readdatavalid, waitrequest)
// ---------------------------------------------------------------------------
module avm_mem_tester #(
   parameter int unsigned        ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
   parameter int unsigned        NUM_WORDS = 1024,
   parameter int unsigned        MAX_PEND  = 4,
   parameter logic [31:0]        SEED      = 32'hACE1
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       error_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest
);

   localparam int unsigned      CNT_W    = $clog2(NUM_WORDS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
   localparam logic [3:0]       PEND_MAX = 4'(MAX_PEND);
   // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
   localparam logic [31:0]      SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_req_cnt;    // words issued in the current phase
   logic [CNT_W-1:0]  r_ret_cnt;    // words returned, gives the checked address
   logic [3:0]        r_pend;       // reads accepted but not yet returned
   logic [31:0]       r_gen_lfsr;
   logic [31:0]       r_chk_lfsr;
   logic [15:0]       r_err_cnt;
   logic [ADDR_W-1:0] r_first_err;

   logic              w_start_ok;
   logic              w_rd_req;
   logic              w_req;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_last_req;
   logic              w_rdv_ok;
   logic              w_mismatch;
   logic [ADDR_W-1:0] w_req_addr;
   logic [ADDR_W-1:0] w_ret_addr;

   function automatic logic [31:0] f_lfsr_next(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0000_0000);
   endfunction

   assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
   // Pend only grows on an accepted read, so a stalled read stays asserted.
   assign w_rd_req   = (r_state == S_READ) && (r_pend < PEND_MAX);
   assign w_req      = w_rd_req || (r_state == S_WRITE);
   assign w_wr_acc   = (r_state == S_WRITE) && !avm_waitrequest;
   assign w_rd_acc   = w_rd_req && !avm_waitrequest;
   assign w_last_req = (r_req_cnt == LAST_IDX);
   assign w_rdv_ok   = avm_readdatavalid && (r_state == S_READ || r_state == S_DRAIN);
   assign w_mismatch = w_rdv_ok && (avm_readdata != r_chk_lfsr);
   assign w_req_addr = BASE_ADDR + (ADDR_W'(r_req_cnt) << 2);
   assign w_ret_addr = BASE_ADDR + (ADDR_W'(r_ret_cnt) << 2);

   assign busy           = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
   assign done           = (r_state == S_DONE);
   assign pass           = done && (r_err_cnt == 16'd0);
   assign error_count    = r_err_cnt;
   assign first_err_addr = r_first_err;
   assign avm_write      = (r_state == S_WRITE);
   assign avm_read       = w_rd_req;
   // Bus fields are zeroed whenever no request is presented.
   assign avm_address    = w_req ? w_req_addr : '0;
   assign avm_writedata  = (r_state == S_WRITE) ? r_gen_lfsr : 32'd0;
   assign avm_byteenable = w_req ? 4'hF : 4'h0;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) r_state <= S_IDLE;
      else                r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start)                    w_state_next = S_WRITE;
         S_WRITE:        if (w_wr_acc && w_last_req)   w_state_next = S_READ;
         S_READ:         if (w_rd_acc && w_last_req)   w_state_next = S_DRAIN;
         S_DRAIN:        if (r_pend == 4'd0)           w_state_next = S_DONE;
         default:                                      w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_req_cnt   <= '0;
         r_ret_cnt   <= '0;
         r_pend      <= 4'd0;
         r_gen_lfsr  <= SEED_EFF;
         r_chk_lfsr  <= SEED_EFF;
         r_err_cnt   <= 16'd0;
         r_first_err <= '0;
      end else begin
         if (w_start_ok) begin
            r_req_cnt   <= '0;
            r_ret_cnt   <= '0;
            r_pend      <= 4'd0;
            r_gen_lfsr  <= SEED_EFF;
            r_err_cnt   <= 16'd0;
            r_first_err <= '0;
         end

         if (w_wr_acc) begin
            r_gen_lfsr <= f_lfsr_next(r_gen_lfsr);
            if (w_last_req) begin
               // Read phase restarts the address count and the expected sequence.
               r_req_cnt  <= '0;
               r_ret_cnt  <= '0;
               r_chk_lfsr <= SEED_EFF;
            end else begin
               r_req_cnt <= r_req_cnt + 1'b1;
            end
         end

         if (w_rd_acc)
            r_req_cnt <= r_req_cnt + 1'b1;

         // Simultaneous issue and return leave pend unchanged.
         if (w_rd_acc && !(w_rdv_ok && r_pend != 4'd0))
            r_pend <= r_pend + 4'd1;
         else if (!w_rd_acc && w_rdv_ok && r_pend != 4'd0)
            r_pend <= r_pend - 4'd1;

         if (w_rdv_ok) begin
            r_chk_lfsr <= f_lfsr_next(r_chk_lfsr);
            r_ret_cnt  <= r_ret_cnt + 1'b1;
            if (w_mismatch) begin
               if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
               if (r_err_cnt == 16'd0)    r_first_err <= w_ret_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_avm_mem_tester.sv
// ---------------------------------------------------------------------------
// tb_avm_mem_tester
//   Drives avm_mem_tester (8 words at 0x1000, 4 outstanding reads) against a
//   behavioural Avalon-MM memory with optional random waitrequest, a
//   configurable read latency and an optional bit flip on word 5. Expected
//   write/read transactions are queued before each run and consumed as the
//   DUT issues them; end-of-run status is compared against a vector table.
// ---------------------------------------------------------------------------
module tb_avm_mem_tester;

   localparam int          NW   = 8;
   localparam int          MP   = 4;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] SEED = 32'hACE1;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, pass;
   logic [15:0] error_count;
   logic [31:0] first_err_addr, avm_address, avm_writedata, avm_readdata;
   logic        avm_read, avm_write, avm_readdatavalid, avm_waitrequest;
   logic [3:0]  avm_byteenable;

   avm_mem_tester #(
      .ADDR_W(32), .BASE_ADDR(BASE), .NUM_WORDS(NW), .MAX_PEND(MP), .SEED(SEED)
   ) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start),
      .busy(busy), .done(done), .pass(pass), .error_count(error_count),
      .first_err_addr(first_err_addr), .avm_address(avm_address),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
   );

   initial forever #5 clk_clk = ~clk_clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_nx(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // ---------------- memory model ----------------
   typedef struct { int idx; int due; } rsp_t;
   logic [31:0]  mem [NW];
   rsp_t         rq[$];
   logic [63:0]  exp_wr[$];     // {addr, data}
   logic [31:0]  exp_rd[$];     // addr
   int           cyc = 0;
   int           o_cnt = 0;
   int           max_o = 0;
   bit           m_rnd = 0;
   int           m_lat = 1;
   bit           m_flip = 0;
   bit           stalled = 0;
   logic [65:0]  prev_req;

   initial forever begin
      @(posedge clk_clk);
      cyc++;
      if (!reset_reset_n) begin
         o_cnt   = 0;
         stalled = 0;
      end else begin
         if (stalled)
            check("stall_hold", {avm_read, avm_write, avm_address, avm_writedata}, prev_req);
         stalled  = (avm_read || avm_write) && avm_waitrequest;
         prev_req = {avm_read, avm_write, avm_address, avm_writedata};
         if (avm_write && !avm_waitrequest) begin
            check("wr_expected", 128'(exp_wr.size() != 0), 128'd1);
            if (exp_wr.size() != 0)
               check("wr_addr_data", {avm_address, avm_writedata, avm_byteenable},
                     {exp_wr.pop_front(), 4'hF});
            mem[avm_address[4:2]] = avm_writedata;
         end
         if (avm_read && !avm_waitrequest) begin
            check("rd_expected", 128'(exp_rd.size() != 0), 128'd1);
            if (exp_rd.size() != 0)
               check("rd_addr", {avm_address, avm_byteenable}, {exp_rd.pop_front(), 4'hF});
            rq.push_back('{int'(avm_address[4:2]), cyc + m_lat - 1});
            o_cnt++;
         end
         if (avm_readdatavalid) o_cnt--;
         if (avm_read && !avm_waitrequest)
            check("max_pend", 128'(o_cnt <= MP), 128'd1);
         if (o_cnt > max_o) max_o = o_cnt;
      end
   end

   initial begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'd0;
      forever begin
         @(negedge clk_clk);
         avm_readdatavalid = 1'b0;
         avm_readdata      = 32'd0;
         avm_waitrequest   = m_rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         if (reset_reset_n && rq.size() != 0 && rq[0].due <= cyc) begin
            rsp_t r;
            r = rq.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem[r.idx] ^ ((m_flip && r.idx == 5) ? 32'd1 : 32'd0);
         end
      end
   end

   // ---------------- run helpers ----------------
   task automatic prep_expected();
      logic [31:0] d;
      d = SEED;
      exp_wr.delete();
      exp_rd.delete();
      for (int i = 0; i < NW; i++) begin
         exp_wr.push_back({BASE + 32'(4 * i), d});
         exp_rd.push_back(BASE + 32'(4 * i));
         d = lfsr_nx(d);
      end
   endtask

   typedef struct {
      string       name;
      bit          rnd;
      int          lat;
      bit          flip;
      int          poke;
      logic [15:0] exp_err;
      logic [31:0] exp_first;
      bit          exp_pass;
      bit          chk_lat;
   } vec_t;

   task automatic run_test(input vec_t v);
      int n;
      m_rnd  = v.rnd;
      m_lat  = v.lat;
      m_flip = v.flip;
      max_o  = 0;
      prep_expected();
      @(negedge clk_clk); start = 1'b1;
      @(negedge clk_clk); start = 1'b0;
      n = 1;
      check({v.name, "_started"}, {busy, done, error_count, first_err_addr},
            {1'b1, 1'b0, 16'd0, 32'd0});
      while (!done && n < 2000) begin
         @(negedge clk_clk);
         n++;
         start = (v.poke != 0 && n == v.poke);
      end
      start = 1'b0;
      check({v.name, "_no_timeout"}, 128'(done), 128'd1);
      check({v.name, "_status"}, {busy, done, pass, error_count, first_err_addr},
            {1'b0, 1'b1, v.exp_pass, v.exp_err, v.exp_first});
      check({v.name, "_sb_empty"}, 128'(exp_wr.size() + exp_rd.size()), 128'd0);
      if (v.chk_lat)
         check({v.name, "_latency_ok"}, 128'(n >= 2*NW + 2 && n <= 2*NW + 4), 128'd1);
      if (v.lat >= 10)
         check({v.name, "_window_used"}, 128'(max_o), 128'(MP));
      $display("[TB] run %s: cycles=%0d err=%0d first=%h pass=%0d max_pend=%0d",
               v.name, n, error_count, first_err_addr, pass, max_o);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{"nominal",  0,  1, 0,  0, 16'd0, 32'd0,       1'b1, 1'b1};
      vecs[1] = '{"waitrnd",  1,  1, 0,  0, 16'd0, 32'd0,       1'b1, 1'b0};
      vecs[2] = '{"flip5",    0,  1, 1,  0, 16'd1, BASE + 32'd20, 1'b0, 1'b0};
      vecs[3] = '{"lat10",    0, 10, 0,  0, 16'd0, 32'd0,       1'b1, 1'b0};
      vecs[4] = '{"rnd_flip", 1,  3, 1, 12, 16'd1, BASE + 32'd20, 1'b0, 1'b0};
      vecs[5] = '{"poke_wr",  1,  2, 0,  4, 16'd0, 32'd0,       1'b1, 1'b0};

      repeat (3) @(negedge clk_clk);
      check("reset_outputs",
            {busy, done, pass, error_count, first_err_addr, avm_address, avm_read,
             avm_write, avm_writedata, avm_byteenable}, 128'd0);
      reset_reset_n = 1'b1;
      @(negedge clk_clk);
      check("idle_after_reset", {busy, done, avm_read, avm_write}, 128'd0);

      for (int i = 0; i < 6; i++) run_test(vecs[i]);

      // Abort mid-WRITE: reset drops everything at once, then a clean rerun.
      m_rnd = 0; m_lat = 1; m_flip = 0;
      prep_expected();
      @(negedge clk_clk); start = 1'b1;
      @(negedge clk_clk); start = 1'b0;
      repeat (3) @(negedge clk_clk);
      check("midwrite_busy", {busy, avm_write}, {1'b1, 1'b1});
      reset_reset_n = 1'b0;
      #1;
      check("midwrite_reset_outputs",
            {busy, done, pass, error_count, first_err_addr, avm_address, avm_read,
             avm_write, avm_writedata, avm_byteenable}, 128'd0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      rq.delete();
      exp_wr.delete();
      exp_rd.delete();
      o_cnt = 0;
      $display("[TB] run midwrite_reset: outputs cleared");
      run_test(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
